// File: rtl/dcache_dm_block.sv
// Direct-mapped, write-through, no-write-allocate data cache with multi-word blocks.
// A load miss refills the whole block over a req/ack word port while the CPU is stalled.
module dcache_dm_block #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 4,
    parameter int OFF_BITS   = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wd,
    input  logic [1:0]            i_cpu_dtype,
    output logic [DATA_WIDTH-1:0] o_cpu_rd,
    output logic                  o_cpu_ready,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wd,
    output logic [3:0]            o_mem_be,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rd,
    output logic [CNT_WIDTH-1:0]  o_hit_cnt,
    output logic [CNT_WIDTH-1:0]  o_miss_cnt
);

    localparam int TAG_W = ADDR_WIDTH - SET_BITS - OFF_BITS - 2;
    localparam int LINES = 1 << SET_BITS;
    localparam int WORDS = 1 << OFF_BITS;

    typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_t;

    state_t                r_state, w_state_d;
    logic [OFF_BITS-1:0]   r_word, w_word_d;
    logic                  r_refilled;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES*WORDS];
    logic [CNT_WIDTH-1:0]  r_hit_cnt, r_miss_cnt;

    logic [TAG_W-1:0]      w_tag;
    logic [SET_BITS-1:0]   w_set;
    logic [OFF_BITS-1:0]   w_woff;
    logic                  w_hit, w_rsvd;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wd_rep;
    logic                  w_count_hit, w_count_miss, w_inval;
    logic                  w_refill_wr, w_fill_done, w_write_upd;

    assign w_tag  = i_cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_set  = i_cpu_addr[OFF_BITS+2 +: SET_BITS];
    assign w_woff = i_cpu_addr[2 +: OFF_BITS];
    assign w_hit  = r_valid[w_set] && (r_tag[w_set] == w_tag);
    assign w_rsvd = (i_cpu_dtype == 2'b11);

    always_comb begin
        w_be     = 4'h0;
        w_wd_rep = i_cpu_wd;
        case (i_cpu_dtype)
            2'b00: w_be = 4'hF;
            2'b01: begin
                w_be     = 4'b0001 << i_cpu_addr[1:0];
                w_wd_rep = {4{i_cpu_wd[7:0]}};
            end
            2'b10: begin
                w_be     = i_cpu_addr[1] ? 4'b1100 : 4'b0011;
                w_wd_rep = {2{i_cpu_wd[15:0]}};
            end
            default: w_be = 4'h0;
        endcase
    end

    always_comb begin
        w_state_d    = r_state;
        w_word_d     = r_word;
        o_cpu_ready  = 1'b0;
        o_cpu_rd     = '0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wd     = '0;
        o_mem_be     = 4'h0;
        w_count_hit  = 1'b0;
        w_count_miss = 1'b0;
        w_inval      = 1'b0;
        w_refill_wr  = 1'b0;
        w_fill_done  = 1'b0;
        w_write_upd  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_cpu_req && !i_rst) begin
                    if (w_rsvd) begin
                        o_cpu_ready = 1'b1;
                    end else if (i_cpu_we) begin
                        w_state_d = StWrite;
                    end else if (w_hit) begin
                        o_cpu_ready = 1'b1;
                        o_cpu_rd    = r_data[{w_set, w_woff}];
                        // The hit that completes a refilled miss is not a second event.
                        w_count_hit = !r_refilled;
                    end else begin
                        w_state_d    = StRefill;
                        w_word_d     = '0;
                        w_count_miss = 1'b1;
                        w_inval      = 1'b1;
                    end
                end
            end
            StRefill: begin
                o_mem_req  = 1'b1;
                o_mem_addr = {w_tag, w_set, r_word, 2'b00};
                o_mem_be   = 4'hF;
                if (i_mem_ack) begin
                    w_refill_wr = 1'b1;
                    w_word_d    = r_word + OFF_BITS'(1);
                    if (r_word == OFF_BITS'(WORDS - 1)) begin
                        w_fill_done = 1'b1;
                        w_state_d   = StIdle;
                    end
                end
            end
            StWrite: begin
                o_mem_req  = 1'b1;
                o_mem_we   = 1'b1;
                o_mem_addr = {i_cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                o_mem_wd   = w_wd_rep;
                o_mem_be   = w_be;
                if (i_mem_ack) begin
                    o_cpu_ready = 1'b1;
                    w_write_upd = w_hit;
                    w_state_d   = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_word     <= '0;
            r_refilled <= 1'b0;
            r_valid    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_word     <= w_word_d;
            r_refilled <= w_fill_done;
            if (w_inval) begin
                r_valid[w_set] <= 1'b0;
            end else if (w_fill_done) begin
                r_valid[w_set] <= 1'b1;
            end
            if (w_count_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
            end
            if (w_count_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Tag and data arrays need no reset: the valid bits gate every use.
    always_ff @(posedge i_clk) begin
        if (w_refill_wr) begin
            r_data[{w_set, r_word}] <= i_mem_rd;
        end
        if (w_fill_done) begin
            r_tag[w_set] <= w_tag;
        end
        if (w_write_upd) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (w_be[b]) begin
                    r_data[{w_set, w_woff}][8*b +: 8] <= w_wd_rep[8*b +: 8];
                end
            end
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_dcache_dm_block.sv
// Bench for dcache_dm_block: table of CPU accesses against a randomly delayed memory responder,
// with load data checked from a scoreboard queue and hand-written reset/abort sequences.
module tb_dcache_dm_block;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_cpu_req, i_cpu_we;
    logic [15:0] i_cpu_addr;
    logic [31:0] i_cpu_wd;
    logic [1:0]  i_cpu_dtype;
    logic [31:0] o_cpu_rd;
    logic        o_cpu_ready, o_mem_req, o_mem_we;
    logic [15:0] o_mem_addr;
    logic [31:0] o_mem_wd;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rd = '0;
    logic [31:0] o_hit_cnt, o_miss_cnt;

    always #5 clk = ~clk;

    dcache_dm_block dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_cpu_req   (i_cpu_req),
        .i_cpu_we    (i_cpu_we),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wd    (i_cpu_wd),
        .i_cpu_dtype (i_cpu_dtype),
        .o_cpu_rd    (o_cpu_rd),
        .o_cpu_ready (o_cpu_ready),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wd    (o_mem_wd),
        .o_mem_be    (o_mem_be),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rd    (i_mem_rd),
        .o_hit_cnt   (o_hit_cnt),
        .o_miss_cnt  (o_miss_cnt)
    );

    // exp: 0 load miss, 1 load hit, 2 store, 3 reserved dtype
    typedef struct {
        string       name;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [1:0]  dtype;
        int          exp;
    } vec_t;

    int n_cmp = 0, n_fail = 0;
    logic [31:0] mem     [16384];
    logic [31:0] ref_mem [16384];
    int n_txn = 0, wait_cnt = -1, delay_max = 5, bad_rd_be = 0;
    bit delay_fixed = 1'b0;
    logic [15:0] rd_log [$];
    logic [31:0] exp_q  [$];
    logic [3:0]  log_be;
    logic [31:0] log_wd;
    logic [15:0] log_addr;
    int exp_hits = 0, exp_misses = 0;

    // Word-wide backing memory with 0..delay_max cycles of ack latency.
    always @(negedge clk) begin
        if (i_rst) begin
            i_mem_ack <= 1'b0;
            wait_cnt = -1;
        end else if (i_mem_ack) begin
            i_mem_ack <= 1'b0;
        end else if (o_mem_req) begin
            if (wait_cnt < 0) wait_cnt = delay_fixed ? delay_max : int'($urandom_range(0, delay_max));
            if (wait_cnt == 0) begin
                wait_cnt = -1;
                i_mem_ack <= 1'b1;
                n_txn++;
                if (o_mem_we) begin
                    log_be   = o_mem_be;
                    log_wd   = o_mem_wd;
                    log_addr = o_mem_addr;
                    for (int b = 0; b < 4; b++)
                        if (o_mem_be[b]) mem[o_mem_addr[15:2]][8*b +: 8] = o_mem_wd[8*b +: 8];
                end else begin
                    i_mem_rd <= mem[o_mem_addr[15:2]];
                    rd_log.push_back(o_mem_addr);
                    if (o_mem_be != 4'hF) bad_rd_be++;
                end
            end else begin
                wait_cnt--;
            end
        end
    end

    function automatic vec_t mk(string n, logic we, logic [15:0] a, logic [31:0] wd,
                                logic [1:0] dt, int e);
        vec_t v;
        v.name = n; v.we = we; v.addr = a; v.wd = wd; v.dtype = dt; v.exp = e;
        return v;
    endfunction

    function automatic logic [3:0] exp_be(logic [1:0] dt, logic [15:0] a);
        case (dt)
            2'b00:   return 4'hF;
            2'b01:   return 4'b0001 << a[1:0];
            2'b10:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(logic [1:0] dt, logic [31:0] wd);
        case (dt)
            2'b01:   return {4{wd[7:0]}};
            2'b10:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic access(input vec_t v);
        int          cyc, txn0;
        logic        got;
        logic [31:0] rd, e;
        logic [3:0]  be;
        @(negedge clk);
        i_cpu_we = v.we; i_cpu_addr = v.addr; i_cpu_wd = v.wd; i_cpu_dtype = v.dtype;
        i_cpu_req = 1'b1;
        txn0 = n_txn; cyc = 0; got = 1'b0; rd = '0;
        if (v.exp == 0 || v.exp == 1) exp_q.push_back(ref_mem[v.addr[15:2]]);
        if (v.exp == 2) begin
            be = exp_be(v.dtype, v.addr);
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[v.addr[15:2]][8*b +: 8] = exp_wd(v.dtype, v.wd) >> (8*b);
        end
        while (!got && cyc < 200) begin
            #1;
            if (o_cpu_ready) begin
                got = 1'b1;
                rd  = o_cpu_rd;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: no cpu_ready within 200 cycles, required ready", v.name);
            i_cpu_req = 1'b0;
            return;
        end
        case (v.exp)
            0, 1: begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL %s_sb: got empty scoreboard, required one entry", v.name);
                end else begin
                    e = exp_q.pop_front();
                    check({v.name, "_rd"}, rd, e);
                end
                if (v.exp == 1) begin
                    check({v.name, "_hit_lat_traffic"}, {cyc, n_txn - txn0}, {32'd0, 32'd0});
                    exp_hits++;
                end else begin
                    check({v.name, "_refill_words"}, n_txn - txn0, 4);
                    check({v.name, "_miss_lat_ok"}, 32'(cyc >= 5), 1);
                    check({v.name, "_refill_be"}, bad_rd_be, 0);
                    exp_misses++;
                end
            end
            2: begin
                check({v.name, "_wr_txn"}, n_txn - txn0, 1);
                check({v.name, "_mem_be"}, 32'(log_be), 32'(exp_be(v.dtype, v.addr)));
                check({v.name, "_mem_wd"}, log_wd, exp_wd(v.dtype, v.wd));
                check({v.name, "_mem_addr"}, 32'(log_addr), 32'({v.addr[15:2], 2'b00}));
            end
            default: check({v.name, "_rsvd_lat_traffic"}, {cyc, n_txn - txn0}, {32'd0, 32'd0});
        endcase
        @(posedge clk);
        #1;
        i_cpu_req = 1'b0;
        check({v.name, "_hit_cnt"}, o_hit_cnt, exp_hits);
        check({v.name, "_miss_cnt"}, o_miss_cnt, exp_misses);
    endtask

    vec_t tbl [$];

    initial begin
        int cyc, txn0;
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = (i * 32'h9E37_79B1) ^ 32'h5A00_00A5;
            ref_mem[i] = mem[i];
        end
        i_rst = 1'b1; i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_addr = '0;
        i_cpu_wd = '0; i_cpu_dtype = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready_req_we", {29'd0, o_cpu_ready, o_mem_req, o_mem_we}, 0);
        check("rst_mem_addr_be", {o_mem_addr, 12'd0, o_mem_be}, 0);
        check("rst_mem_wd", o_mem_wd, 0);
        check("rst_cpu_rd", o_cpu_rd, 0);
        check("rst_counters", o_hit_cnt | o_miss_cnt, 0);
        @(negedge clk);
        i_rst = 1'b0;

        access(mk("ld_0104_cold", 1'b0, 16'h0104, 0, 2'b00, 0));
        check("refill_count", rd_log.size(), 4);
        for (int k = 0; k < 4 && k < rd_log.size(); k++)
            check("refill_addr_order", 32'(rd_log[k]), 32'h0100 + 32'(4 * k));
        check("first_miss_cnt", o_miss_cnt, 1);

        tbl.push_back(mk("ld_0100", 1'b0, 16'h0100, 0, 2'b00, 1));
        tbl.push_back(mk("ld_0108", 1'b0, 16'h0108, 0, 2'b00, 1));
        tbl.push_back(mk("ld_010c", 1'b0, 16'h010C, 0, 2'b00, 1));
        tbl.push_back(mk("ld_0204_evict", 1'b0, 16'h0204, 0, 2'b00, 0));
        tbl.push_back(mk("ld_0104_again", 1'b0, 16'h0104, 0, 2'b00, 0));
        tbl.push_back(mk("sb_0101", 1'b1, 16'h0101, 32'h0000_00AB, 2'b01, 2));
        tbl.push_back(mk("ld_0100_byte", 1'b0, 16'h0100, 0, 2'b00, 1));
        tbl.push_back(mk("sh_0106", 1'b1, 16'h0106, 32'hFFFF_1234, 2'b10, 2));
        tbl.push_back(mk("ld_0104_half", 1'b0, 16'h0104, 0, 2'b00, 1));
        tbl.push_back(mk("sw_010b", 1'b1, 16'h010B, 32'hDEAD_BEEF, 2'b00, 2));
        tbl.push_back(mk("ld_0108_word", 1'b0, 16'h0108, 0, 2'b00, 1));
        tbl.push_back(mk("sw_0300_nocache", 1'b1, 16'h0300, 32'hCAFE_F00D, 2'b00, 2));
        tbl.push_back(mk("ld_0300_noalloc", 1'b0, 16'h0300, 0, 2'b00, 0));
        tbl.push_back(mk("ld_0104_evicted", 1'b0, 16'h0104, 0, 2'b00, 0));
        tbl.push_back(mk("rsvd_ld_0104", 1'b0, 16'h0104, 0, 2'b11, 3));
        tbl.push_back(mk("rsvd_st_0108", 1'b1, 16'h0108, 32'h1111_2222, 2'b11, 3));
        tbl.push_back(mk("ld_0108_post_rsvd", 1'b0, 16'h0108, 0, 2'b00, 1));
        tbl.push_back(mk("sb_0213_set1", 1'b1, 16'h0213, 32'h0000_005A, 2'b01, 2));
        tbl.push_back(mk("ld_0210_set1", 1'b0, 16'h0210, 0, 2'b00, 0));
        tbl.push_back(mk("ld_021c_set1", 1'b0, 16'h021C, 0, 2'b00, 1));
        tbl.push_back(mk("sh_0210_lo", 1'b1, 16'h0210, 32'h0000_BEEF, 2'b10, 2));
        tbl.push_back(mk("ld_0210_lo", 1'b0, 16'h0210, 0, 2'b00, 1));
        foreach (tbl[i]) access(tbl[i]);

        // Abort a refill while word 1 is outstanding.
        delay_fixed = 1'b1; delay_max = 4;
        @(negedge clk);
        i_cpu_we = 1'b0; i_cpu_addr = 16'h0504; i_cpu_dtype = 2'b00; i_cpu_req = 1'b1;
        txn0 = n_txn; cyc = 0;
        while (n_txn < txn0 + 1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_word0_acked", n_txn - txn0, 1);
        repeat (2) @(negedge clk);
        #1;
        check("abort_req_pending", {31'd0, o_mem_req}, 1);
        i_rst = 1'b1;
        #1;
        check("abort_req_drops", {30'd0, o_mem_req, o_mem_we}, 0);
        check("abort_ready_low", {31'd0, o_cpu_ready}, 0);
        i_cpu_req = 1'b0;
        exp_hits = 0; exp_misses = 0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        #1;
        check("abort_counters", o_hit_cnt | o_miss_cnt, 0);
        check("abort_no_extra_txn", n_txn - txn0, 1);
        delay_fixed = 1'b0; delay_max = 5;
        access(mk("ld_0500_after_abort", 1'b0, 16'h0500, 0, 2'b00, 0));
        access(mk("ld_0504_after_refill", 1'b0, 16'h0504, 0, 2'b00, 1));
        access(mk("ld_0104_after_rst", 1'b0, 16'h0104, 0, 2'b00, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
